// File: rtl/raster_stamp_csr_unit_pkg.sv
// Shared types for the raster stamp consumer: stamp/CSR layouts, CSR word
// indices, FSM state encoding and a word-select helper for CSR reads.
package raster_types;

  typedef struct packed {
    logic [15:0]      pos_x;
    logic [15:0]      pos_y;
    logic [3:0]       mask;
    logic [15:0]      pid;
    logic [3:0][31:0] bcoord_x;
    logic [3:0][31:0] bcoord_y;
    logic [3:0][31:0] bcoord_z;
  } raster_stamp_t;

  typedef struct packed {
    logic [31:0]      pos_y_x;
    logic [31:0]      pid_mask;
    logic [3:0][31:0] bcoord_x;
    logic [3:0][31:0] bcoord_y;
    logic [3:0][31:0] bcoord_z;
    logic [31:0]      grad_x;
    logic [31:0]      grad_y;
  } raster_csrs_t;

  localparam int unsigned RASTER_STAMP_W = $bits(raster_stamp_t);
  localparam int unsigned RASTER_CSRS_W  = $bits(raster_csrs_t);

  localparam logic [3:0] RASTER_CSR_POS_Y_X   = 4'd0;
  localparam logic [3:0] RASTER_CSR_PID_MASK  = 4'd1;
  localparam logic [3:0] RASTER_CSR_BCOORD_X0 = 4'd2;
  localparam logic [3:0] RASTER_CSR_BCOORD_Y0 = 4'd6;
  localparam logic [3:0] RASTER_CSR_BCOORD_Z0 = 4'd10;
  localparam logic [3:0] RASTER_CSR_GRAD_X    = 4'd14;
  localparam logic [3:0] RASTER_CSR_GRAD_Y    = 4'd15;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StResp
  } raster_state_e;

  // Select one 32-bit word of a CSR set by word index.
  function automatic logic [31:0] raster_csr_word(raster_csrs_t c, logic [3:0] addr);
    logic [31:0] word;
    word = '0;
    case (addr)
      4'd0:  word = c.pos_y_x;
      4'd1:  word = c.pid_mask;
      4'd2:  word = c.bcoord_x[0];
      4'd3:  word = c.bcoord_x[1];
      4'd4:  word = c.bcoord_x[2];
      4'd5:  word = c.bcoord_x[3];
      4'd6:  word = c.bcoord_y[0];
      4'd7:  word = c.bcoord_y[1];
      4'd8:  word = c.bcoord_y[2];
      4'd9:  word = c.bcoord_y[3];
      4'd10: word = c.bcoord_z[0];
      4'd11: word = c.bcoord_z[1];
      4'd12: word = c.bcoord_z[2];
      4'd13: word = c.bcoord_z[3];
      4'd14: word = c.grad_x;
      4'd15: word = c.grad_y;
      default: word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/raster_stamp_csr_unit_pack.sv
// raster_csr_pack: combinational repack of one raster stamp into the CSR
// layout. Gradient words are built only when RASTER_CSR_GRAD_EN is defined;
// otherwise they are tied to zero and no subtractors exist.
module raster_csr_pack
  import raster_types::*;
(
  input  logic [RASTER_STAMP_W-1:0] stamp_i,
  output logic [RASTER_CSRS_W-1:0]  csrs_o
);

  raster_stamp_t stamp;
  raster_csrs_t  csrs;

  assign stamp  = raster_stamp_t'(stamp_i);
  assign csrs_o = csrs;

  // Field repacking plus optional gradient computation.
  always_comb begin
    csrs          = '0;
    csrs.pos_y_x  = {stamp.pos_y, stamp.pos_x};
    csrs.pid_mask = {stamp.pid, 12'h000, stamp.mask};
    csrs.bcoord_x = stamp.bcoord_x;
    csrs.bcoord_y = stamp.bcoord_y;
    csrs.bcoord_z = stamp.bcoord_z;
`ifdef RASTER_CSR_GRAD_EN
    // Plain 32-bit wrap-around differences.
    csrs.grad_x   = stamp.bcoord_x[1] - stamp.bcoord_x[0];
    csrs.grad_y   = stamp.bcoord_x[2] - stamp.bcoord_x[0];
`else
    csrs.grad_x   = '0;
    csrs.grad_y   = '0;
`endif
  end

endmodule

// File: rtl/raster_stamp_csr_unit.sv
// raster_stamp_csr_unit: accepts one raster stamp per active lane of a warp
// fetch, stores the repacked CSR set per lane and replies with the mask of
// lanes that got a stamp. Optional gradient words: RASTER_CSR_GRAD_EN.
module raster_stamp_csr_unit
  import raster_types::*;
#(
  parameter int unsigned NUM_LANES = 4,
  localparam int unsigned LaneW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      stamp_valid_i,
  input  logic [RASTER_STAMP_W-1:0] stamp_data_i,
  output logic                      stamp_ready_o,
  input  logic                      stamp_done_i,
  input  logic                      fetch_valid_i,
  input  logic [NUM_LANES-1:0]      fetch_tmask_i,
  output logic                      fetch_ready_o,
  output logic                      rsp_valid_o,
  output logic [NUM_LANES-1:0]      rsp_tmask_o,
  input  logic                      rsp_ready_i,
  input  logic [LaneW-1:0]          csr_lane_i,
  input  logic [3:0]                csr_addr_i,
  output logic [31:0]               csr_data_o
);

  raster_state_e          state_q, state_d;
  logic [NUM_LANES-1:0]   pending_q, pending_d;
  logic [NUM_LANES-1:0]   filled_q, filled_d;
  raster_csrs_t           csr_q [NUM_LANES];
  raster_csrs_t           csr_d [NUM_LANES];
  raster_csrs_t           stamp_csrs;
  logic [NUM_LANES-1:0]   cur_onehot;
  logic [NUM_LANES-1:0]   pending_after;

  raster_csr_pack u_pack (
    .stamp_i (stamp_data_i),
    .csrs_o  (stamp_csrs)
  );

  // Current lane is the lowest pending bit, kept one-hot to drive write enables.
  assign cur_onehot    = pending_q & (~pending_q + NUM_LANES'(1));
  assign pending_after = pending_q & ~cur_onehot;

  // Handshake outputs come from registered state; reset masks them immediately.
  assign fetch_ready_o = !reset_i && (state_q == StIdle);
  assign stamp_ready_o = !reset_i && (state_q == StFill);
  assign rsp_valid_o   = !reset_i && (state_q == StResp);
  assign rsp_tmask_o   = rsp_valid_o ? filled_q : '0;

  // Next-state, lane bookkeeping and CSR write data.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    filled_d  = filled_q;
    csr_d     = csr_q;
    unique case (state_q)
      StIdle: begin
        if (fetch_valid_i) begin
          pending_d = fetch_tmask_i;
          filled_d  = '0;
          state_d   = (fetch_tmask_i == '0) ? StResp : StFill;
        end
      end
      StFill: begin
        // A stamp arriving together with done is consumed before the flush.
        if (stamp_valid_i) begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (cur_onehot[i]) csr_d[i] = stamp_csrs;
          end
          filled_d  = filled_q | cur_onehot;
          pending_d = pending_after;
          if (pending_after == '0) state_d = StResp;
        end else if (stamp_done_i) begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (pending_q[i]) csr_d[i] = '0;
          end
          pending_d = '0;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and CSR storage with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      pending_q <= '0;
      filled_q  <= '0;
      for (int i = 0; i < NUM_LANES; i++) csr_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      filled_q  <= filled_d;
      for (int i = 0; i < NUM_LANES; i++) csr_q[i] <= csr_d[i];
    end
  end

  // Combinational read port; reads see the pre-write value in a write cycle.
  always_comb begin
    csr_data_o = '0;
    if (32'(csr_lane_i) < NUM_LANES) begin
      csr_data_o = raster_csr_word(csr_q[csr_lane_i], csr_addr_i);
    end
  end

endmodule

// File: tb/tb_raster_stamp_csr_unit.sv
// Directed self-checking bench for raster_stamp_csr_unit. Expected response
// masks go through a scoreboard queue; per-lane stamp contents are modelled
// and compared word by word through the CSR read port.
module tb_raster_stamp_csr_unit;
  import raster_types::*;

  localparam int unsigned NL = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      stamp_valid;
  logic [RASTER_STAMP_W-1:0] stamp_data;
  logic                      stamp_ready;
  logic                      stamp_done;
  logic                      fetch_valid;
  logic [NL-1:0]             fetch_tmask;
  logic                      fetch_ready;
  logic                      rsp_valid;
  logic [NL-1:0]             rsp_tmask;
  logic                      rsp_ready;
  logic [1:0]                csr_lane;
  logic [3:0]                csr_addr;
  logic [31:0]               csr_data;

  raster_stamp_csr_unit #(.NUM_LANES(NL)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .stamp_valid_i (stamp_valid),
    .stamp_data_i  (stamp_data),
    .stamp_ready_o (stamp_ready),
    .stamp_done_i  (stamp_done),
    .fetch_valid_i (fetch_valid),
    .fetch_tmask_i (fetch_tmask),
    .fetch_ready_o (fetch_ready),
    .rsp_valid_o   (rsp_valid),
    .rsp_tmask_o   (rsp_tmask),
    .rsp_ready_i   (rsp_ready),
    .csr_lane_i    (csr_lane),
    .csr_addr_i    (csr_addr),
    .csr_data_o    (csr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;
  logic [NL-1:0] rsp_q[$];
  raster_stamp_t lane_model [NL];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic raster_stamp_t make_stamp(input int seed);
    raster_stamp_t s;
    s       = '0;
    s.pos_x = 16'(seed);
    s.pos_y = 16'(10 + seed);
    s.pid   = 16'(seed * 3 + 1);
    s.mask  = 4'(seed);
    for (int j = 0; j < 4; j++) begin
      s.bcoord_x[j] = 32'hFFFF_FFF0 + 32'(seed * 5 + j * 9);
      s.bcoord_y[j] = 32'(seed * 1000 + j * 17 + 3);
      s.bcoord_z[j] = 32'hA500_0000 ^ 32'(seed * 77 + j);
    end
    return s;
  endfunction

  function automatic logic [31:0] exp_word(input raster_stamp_t s, input int a);
    logic [31:0] w;
    if (a == 0) w = {s.pos_y, s.pos_x};
    else if (a == 1) w = {s.pid, 12'h000, s.mask};
    else if (a < 6) w = s.bcoord_x[2'(a - 2)];
    else if (a < 10) w = s.bcoord_y[2'(a - 6)];
    else if (a < 14) w = s.bcoord_z[2'(a - 10)];
    else begin
`ifdef RASTER_CSR_GRAD_EN
      w = (a == 14) ? (s.bcoord_x[1] - s.bcoord_x[0]) : (s.bcoord_x[2] - s.bcoord_x[0]);
`else
      w = '0;
`endif
    end
    return w;
  endfunction

  task automatic read_chk(input string tag, input int lane, input int addr,
                          input logic [31:0] exp);
    csr_lane = 2'(lane);
    csr_addr = 4'(addr);
    #1;
    check($sformatf("%s lane%0d addr%0d", tag, lane, addr), csr_data, exp);
  endtask

  task automatic check_lane(input string tag, input int lane);
    for (int a = 0; a < 16; a++) read_chk(tag, lane, a, exp_word(lane_model[lane], a));
  endtask

  task automatic do_fetch(input logic [NL-1:0] m, output int fcyc);
    int n = 0;
    while (fetch_ready !== 1'b1 && n < 20) begin tick(); n++; end
    check("fetch_ready before fetch", 32'(fetch_ready), 32'd1);
    fetch_valid = 1'b1;
    fetch_tmask = m;
    tick();
    fcyc        = cyc;
    fetch_valid = 1'b0;
  endtask

  task automatic send_stamp(input raster_stamp_t s, input int lane);
    int n = 0;
    while (stamp_ready !== 1'b1 && n < 20) begin tick(); n++; end
    check("stamp_ready before stamp", 32'(stamp_ready), 32'd1);
    stamp_valid = 1'b1;
    stamp_data  = s;
    lane_model[lane] = s;
    tick();
    stamp_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int fcyc, input int exp_lat);
    int n = 0;
    logic [NL-1:0] exp;
    while (rsp_valid !== 1'b1 && n < 40) begin tick(); n++; end
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    if (rsp_valid === 1'b1) begin
      exp = (rsp_q.size() > 0) ? rsp_q.pop_front() : 'x;
      check({tag, " rsp_tmask"}, 32'(rsp_tmask), 32'(exp));
      if (exp_lat >= 0) check({tag, " latency"}, 32'(cyc - fcyc), 32'(exp_lat));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
      check({tag, " fetch_ready back"}, 32'(fetch_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc;
    raster_stamp_t s;

    reset = 1'b1; stamp_valid = 1'b0; stamp_data = '0; stamp_done = 1'b0;
    fetch_valid = 1'b0; fetch_tmask = '0; rsp_ready = 1'b0;
    csr_lane = '0; csr_addr = '0;
    for (int l = 0; l < NL; l++) lane_model[l] = '0;

    // Reset behaviour.
    tick();
    tick();
    check("reset fetch_ready", 32'(fetch_ready), 32'd0);
    check("reset stamp_ready", 32'(stamp_ready), 32'd0);
    reset = 1'b0;
    tick();
    check("post-reset fetch_ready", 32'(fetch_ready), 32'd1);
    check("post-reset stamp_ready", 32'(stamp_ready), 32'd0);
    check("post-reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("post-reset rsp_tmask", 32'(rsp_tmask), 32'd0);
    read_chk("post-reset csr", 0, 0, 32'd0);
    read_chk("post-reset csr", 3, 15, 32'd0);

    // Full warp, back-to-back stamps.
    rsp_q.push_back(4'b1111);
    do_fetch(4'b1111, fc);
    check("fill fetch_ready low", 32'(fetch_ready), 32'd0);
    for (int i = 0; i < 4; i++) send_stamp(make_stamp(i), i);
    wait_rsp("full", fc, 4);
    read_chk("full pos", 2, 0, 32'h000C_0002);
    for (int l = 0; l < NL; l++) check_lane("full", l);

    // Early done: lane 1 stamped, lane 3 flushed to zero.
    rsp_q.push_back(4'b0010);
    do_fetch(4'b1010, fc);
    send_stamp(make_stamp(5), 1);
    stamp_done = 1'b1;
    lane_model[3] = '0;
    wait_rsp("done", fc, -1);
    stamp_done = 1'b0;
    check_lane("done", 1);
    check_lane("done", 3);
    check_lane("done keep", 0);

    // Field packing with known values.
    s = '0;
    s.pid = 16'h1234;
    s.mask = 4'b0101;
    s.bcoord_x[0] = 32'd10; s.bcoord_x[1] = 32'd20;
    s.bcoord_x[2] = 32'd30; s.bcoord_x[3] = 32'd40;
    rsp_q.push_back(4'b0001);
    do_fetch(4'b0001, fc);
    send_stamp(s, 0);
    wait_rsp("pack", fc, 1);
    read_chk("pack pid_mask", 0, 1, 32'h1234_0005);
`ifdef RASTER_CSR_GRAD_EN
    read_chk("pack grad_x", 0, 14, 32'd10);
    read_chk("pack grad_y", 0, 15, 32'd20);
`else
    read_chk("pack grad_x", 0, 14, 32'd0);
    read_chk("pack grad_y", 0, 15, 32'd0);
`endif
    read_chk("pack bcx3", 0, 5, 32'd40);

    // Stall mid-fill, then back-pressure on the response.
    rsp_q.push_back(4'b1111);
    do_fetch(4'b1111, fc);
    send_stamp(make_stamp(40), 0);
    send_stamp(make_stamp(41), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall stamp_ready", 32'(stamp_ready), 32'd1);
      check("stall rsp_valid", 32'(rsp_valid), 32'd0);
    end
    send_stamp(make_stamp(42), 2);
    send_stamp(make_stamp(43), 3);
    for (int k = 0; k < 5; k++) begin
      check("hold rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold rsp_tmask", 32'(rsp_tmask), 32'h0000_000F);
      check("hold fetch_ready", 32'(fetch_ready), 32'd0);
      tick();
    end
    wait_rsp("stall", fc, -1);
    for (int l = 0; l < NL; l++) check_lane("stall", l);

    // Zero mask: immediate response, a presented stamp is ignored.
    rsp_q.push_back(4'b0000);
    do_fetch(4'b0000, fc);
    stamp_valid = 1'b1;
    stamp_data  = make_stamp(60);
    check("zero stamp_ready", 32'(stamp_ready), 32'd0);
    wait_rsp("zero", fc, 0);
    stamp_valid = 1'b0;
    check_lane("zero keep", 0);

    // Reset in the middle of a fill aborts it.
    do_fetch(4'b1111, fc);
    send_stamp(make_stamp(20), 0);
    send_stamp(make_stamp(21), 1);
    reset       = 1'b1;
    stamp_valid = 1'b1;
    stamp_data  = make_stamp(22);
    #1;
    check("abort stamp_ready", 32'(stamp_ready), 32'd0);
    check("abort fetch_ready", 32'(fetch_ready), 32'd0);
    tick();
    reset       = 1'b0;
    stamp_valid = 1'b0;
    for (int l = 0; l < NL; l++) lane_model[l] = '0;
    tick();
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort rsp_tmask", 32'(rsp_tmask), 32'd0);
    check("abort stamp_ready idle", 32'(stamp_ready), 32'd0);
    check("abort fetch_ready idle", 32'(fetch_ready), 32'd1);
    for (int l = 0; l < NL; l++) check_lane("abort", l);
    rsp_q.push_back(4'b0100);
    do_fetch(4'b0100, fc);
    send_stamp(make_stamp(30), 2);
    wait_rsp("after abort", fc, 1);
    check_lane("after abort", 2);
    check("scoreboard drained", 32'(rsp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/raster_stamp_csr_unit.md
# raster_stamp_csr_unit

Consumer end of the raster stamp stream. Accepts `raster_stamp_t` stamps from the raster unit, one per active thread of a requesting warp, and repacks each into the `raster_csrs_t` layout. It holds the result in a per-lane CSR file and serves 32-bit CSR reads to the core. It sits between the raster unit output and the core's CSR read path, and replies to each warp fetch with the mask of lanes that received a stamp.

## Interface
- `NUM_LANES`, default 4: threads per warp; one CSR set per lane.
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `stamp_valid`, in, 1: stamp available.
- `stamp_data`, in, 436: `raster_stamp_t`.
- `stamp_ready`, out, 1: stamp accepted when `stamp_valid && stamp_ready`.
- `stamp_done`, in, 1: level signal from the raster unit; no further stamps will arrive.
- `fetch_valid`, in, 1: a warp requests stamps.
- `fetch_tmask`, in, `NUM_LANES`: active lanes.
- `fetch_ready`, out, 1: fetch accepted.
- `rsp_valid`, out, 1: fetch complete.
- `rsp_tmask`, out, `NUM_LANES`: lanes that received a stamp.
- `rsp_ready`, in, 1: response consumed.
- `csr_lane`, in, `$clog2(NUM_LANES)`: lane to read.
- `csr_addr`, in, 4: word index.
- `csr_data`, out, 32: read data, combinational.

## Operation
- FSM states:
  - IDLE: `fetch_ready`=1. A fetch handshake latches `fetch_tmask` into `pending` and clears `filled`. The next state is FILL, or RESP if the mask is zero.
  - FILL: the current lane is the lowest set bit of `pending`.
    - `stamp_ready` = 1 in FILL.
    - On a stamp handshake: write the packed CSRs to the current lane, set its `filled` bit, clear its `pending` bit.
    - When `pending` becomes zero, go to RESP.
    - If `stamp_done` && !`stamp_valid`: write an all-zero CSR set to every remaining pending lane, clear `pending`, go to RESP.
    - If `stamp_valid` and `stamp_done` are both high, the stamp is consumed first.
  - RESP: `rsp_valid`=1 and `rsp_tmask`=`filled`. On `rsp_ready`, go to IDLE.
- Packing:
  - `pos_y_x` = {pos_y, pos_x}.
  - `pid_mask` = {pid, 12'b0, mask}.
  - `bcoord_*` are copied verbatim.
  - `grad_*`: see Configuration.
- CSR address map:
  - 0: pos_y_x
  - 1: pid_mask
  - 2–5: bcoord_x[0..3]
  - 6–9: bcoord_y[0..3]
  - 10–13: bcoord_z[0..3]
  - 14: grad_x
  - 15: grad_y
- Reads of lanes not written by the latest fetch return the values from that lane's last write.
- A read in the same cycle as a write returns the old value.

## Timing
- Reset values:
  - `fetch_ready`=0 during reset, 1 on the first cycle after reset (IDLE).
  - `stamp_ready`=0, `rsp_valid`=0, `rsp_tmask`=0.
  - All CSR storage is 0, so `csr_data`=0.
- Reset asserted mid-FILL or mid-RESP aborts the fetch without a response and returns to IDLE. A stamp presented in that cycle is not consumed.
- Fetch accepted in cycle 0 → FILL in cycle 1. Stamps are consumed at up to 1 per cycle.
- The last stamp accepted in cycle N → `rsp_valid` in cycle N+1. Best case for k active lanes: `rsp_valid` in cycle k+1.
- Zero tmask → `rsp_valid` in cycle 1.
- `rsp_valid` and `rsp_tmask` are held stable until `rsp_ready`. IDLE is re-entered the following cycle, so back-to-back fetches are spaced at least one cycle apart.
- `fetch_ready`, `stamp_ready` and `rsp_valid` are decoded from the registered state only. None depends combinationally on its own valid or ready input.
- Subtractions are 32-bit two's complement with wrap and no saturation.

## Configuration
- `RASTER_CSR_GRAD_EN` defined:
  - grad_x = bcoord_x[1] − bcoord_x[0]
  - grad_y = bcoord_x[2] − bcoord_x[0]
  - Both are computed at write time.
- Not defined: grad_x and grad_y are tied to 0, no subtractors are built, and addresses 14 and 15 read 0.

## Structure
- Package `raster_types`:
  - `raster_stamp_t` and `raster_csrs_t`.
  - CSR word-index constants `RASTER_CSR_POS_Y_X` through `RASTER_CSR_GRAD_Y`.
  - FSM state enum.
- Sub-module `raster_csr_pack`: combinational `raster_stamp_t` → `raster_csrs_t`, containing the grad logic.

## Test plan
- Fetch tmask=4'b1111 with 4 stamps back-to-back (pos_x=i, pos_y=10+i) → `rsp_tmask`=1111 in cycle 5. Lane 2, addr 0 reads 0x000C0002.
- tmask=4'b1010; stamp_done asserted after 1 stamp → `rsp_tmask`=0010. Lane 3 reads all zeros.
- Stamp pid=0x1234, mask=4'b0101, bcoord_x={40,30,20,10} (index 3..0) → addr 1 = 0x12340005. With `RASTER_CSR_GRAD_EN`: addr 14 = 10, addr 15 = 20. Without it: both 0.
- Stall `stamp_valid` for 3 cycles mid-fill, then hold `rsp_ready`=0 for 5 cycles → no lost stamps, `rsp_valid`/`rsp_tmask` stable, `fetch_ready`=0 throughout.
- tmask=0 → `rsp_valid` in cycle 1 with `rsp_tmask`=0 and no stamp consumed.
- Assert `reset` in the cycle after the 2nd stamp of a 4-lane fetch → no response, all outputs at reset values, CSRs read 0, next fetch works normally.
